// File: rtl/nibble_serial_addsub.sv
// 16-bit add/sub built from one 4-bit slice stepped over four nibbles, LSB first.
// Define NIBBLE_SERIAL_ADDSUB_OVF_EN to enable the registered signed-overflow flag.
module nibble_serial_addsub (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sub,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        cout,
  output logic        zero,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t      state;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic        sub_q;
  logic        carry;
  logic [1:0]  idx;
  logic [15:0] work;

  logic [3:0]  bit_lo;
  logic [3:0]  a_nib;
  logic [3:0]  b_nib;
  logic [4:0]  sum5;
  logic [15:0] full;

  always_comb begin
    bit_lo = {idx, 2'b00};
    a_nib  = a_q[bit_lo +: 4];
    b_nib  = b_q[bit_lo +: 4] ^ {4{sub_q}};
    sum5   = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};
    // Top nibble comes straight from the slice on the final step
    full   = {sum5[3:0], work[11:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      sub_q  <= 1'b0;
      carry  <= 1'b0;
      idx    <= 2'd0;
      work   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      zero   <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDSUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE, FIN: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            sub_q <= sub;
            carry <= sub;
            idx   <= 2'd0;
            work  <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          work[bit_lo +: 4] <= sum5[3:0];
          carry <= sum5[4];
          idx   <= idx + 2'd1;
          if (idx == 2'd3) begin
            state  <= FIN;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= full;
            cout   <= sum5[4];
            zero   <= (full == 16'h0000);
`ifdef NIBBLE_SERIAL_ADDSUB_OVF_EN
            ovf    <= (a_q[15] == (b_q[15] ^ sub_q)) &&
                      (full[15] != a_q[15]);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef NIBBLE_SERIAL_ADDSUB_OVF_EN
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed bench for nibble_serial_addsub: hand-computed vectors,
// handshake, back-to-back accept and mid-run reset.
module tb_nibble_serial_addsub;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        cout;
  logic        zero;
  logic        ovf;

  int n_checks = 0;
  int n_fails  = 0;

`ifdef NIBBLE_SERIAL_ADDSUB_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  nibble_serial_addsub dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .zero   (zero),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [15:0] r,
                          input logic c, input logic z, input logic o);
    chk({tag, ".result"}, result, r);
    chk({tag, ".cout"}, {15'd0, cout}, {15'd0, c});
    chk({tag, ".zero"}, {15'd0, zero}, {15'd0, z});
    chk({tag, ".ovf"}, {15'd0, ovf}, {15'd0, o});
  endtask

  // Pulse start for one cycle, check 4 busy cycles, then the done cycle.
  task automatic run_op(input string tag, input logic [15:0] ia,
                        input logic [15:0] ib, input logic isub,
                        input logic [15:0] r, input logic c,
                        input logic z, input logic o);
    @(negedge clk);
    start = 1'b1; a = ia; b = ib; sub = isub;
    @(negedge clk);
    start = 1'b0; a = 16'h5A5A; b = 16'hC3C3; sub = ~isub;
    for (int i = 0; i < 4; i++) begin
      chk({tag, ".busy"}, {15'd0, busy}, 16'd1);
      chk({tag, ".nodone"}, {15'd0, done}, 16'd0);
      @(negedge clk);
    end
    chk({tag, ".done"}, {15'd0, done}, 16'd1);
    chk({tag, ".idle"}, {15'd0, busy}, 16'd0);
    chk_outs(tag, r, c, z, o);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst.busy", {15'd0, busy}, 16'd0);
    chk("rst.done", {15'd0, done}, 16'd0);
    chk_outs("rst", 16'h0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    run_op("add", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("after.done", {15'd0, done}, 16'd0);
    chk("after.busy", {15'd0, busy}, 16'd0);
    chk("hold.result", result, 16'h2233);

    run_op("sub_eq", 16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
    run_op("sub_neg", 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_op("ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, OVF_ON);
    run_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);

    // start while busy must be ignored; old result holds meanwhile
    @(negedge clk);
    start = 1'b1; a = 16'h1111; b = 16'h2222; sub = 1'b0;
    @(negedge clk);
    a = 16'hAAAA; b = 16'hAAAA; sub = 1'b1;
    chk("hs.busy0", {15'd0, busy}, 16'd1);
    chk("hs.hold", result, 16'h0000);
    @(negedge clk);
    chk("hs.busy1", {15'd0, busy}, 16'd1);
    @(negedge clk);
    start = 1'b0;
    chk("hs.busy2", {15'd0, busy}, 16'd1);
    @(negedge clk);
    chk("hs.busy3", {15'd0, busy}, 16'd1);
    chk("hs.nodone", {15'd0, done}, 16'd0);
    @(negedge clk);
    chk("hs.done", {15'd0, done}, 16'd1);
    chk_outs("hs", 16'h3333, 1'b0, 1'b0, 1'b0);

    // accept in the DONE cycle
    start = 1'b1; a = 16'h0100; b = 16'h0200; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("b2b.busy", {15'd0, busy}, 16'd1);
    chk("b2b.nodone", {15'd0, done}, 16'd0);
    repeat (3) @(negedge clk);
    chk("b2b.nodone3", {15'd0, done}, 16'd0);
    @(negedge clk);
    chk("b2b.done", {15'd0, done}, 16'd1);
    chk_outs("b2b", 16'h0300, 1'b0, 1'b0, 1'b0);

    // reset during the 3rd RUN cycle
    @(negedge clk);
    start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid.busy", {15'd0, busy}, 16'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid.busy0", {15'd0, busy}, 16'd0);
    chk("mid.done0", {15'd0, done}, 16'd0);
    chk_outs("mid", 16'h0000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid.nospur", {15'd0, done | busy}, 16'd0);
    end

    run_op("post", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
